jtframe_lfbuf_ddr_resp: RTL and testbench



---
 rtl/jtframe_ddr_pkg.sv | 15 +
 rtl/jtframe_lfbuf_ddr_resp_if.sv | 26 ++
 rtl/jtframe_ddr_bram.sv | 31 +++
 rtl/jtframe_lfbuf_ddr_resp.sv | 145 ++++++++++++++
 tb/tb_jtframe_lfbuf_ddr_resp.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtframe_ddr_pkg.sv
// Shared definitions for the block-RAM backed DDRAM burst responder.
//   DW      : data word width of the DDRAM port
//   BEW     : byte-enable width (one bit per data byte)
//   state_t : responder FSM encoding
package jtframe_ddr_pkg;
  localparam int DW  = 64;
  localparam int BEW = DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRBURST = 2'd1,
    ST_RDWAIT  = 2'd2,
    ST_RDBURST = 2'd3
  } state_t;
endpackage

// File: rtl/jtframe_lfbuf_ddr_resp_if.sv
// MiSTer-style DDRAM burst port.
//   master : initiator side (drives address/command/write data)
//   slave  : memory side (drives busy and read data)
interface jtframe_lfbuf_ddr_resp_if;
  import jtframe_ddr_pkg::*;

  logic [31:3]    ddram_addr;
  logic [7:0]     ddram_burstcnt;
  logic           ddram_rd;
  logic           ddram_we;
  logic [DW-1:0]  ddram_din;
  logic [BEW-1:0] ddram_be;
  logic           ddram_busy;
  logic [DW-1:0]  ddram_dout;
  logic           ddram_dout_ready;

  modport master (
    output ddram_addr, ddram_burstcnt, ddram_rd, ddram_we, ddram_din, ddram_be,
    input  ddram_busy, ddram_dout, ddram_dout_ready
  );

  modport slave (
    input  ddram_addr, ddram_burstcnt, ddram_rd, ddram_we, ddram_din, ddram_be,
    output ddram_busy, ddram_dout, ddram_dout_ready
  );
endinterface

// File: rtl/jtframe_ddr_bram.sv
// Single-port 2^AW x 64 RAM with per-byte write enable and registered read.
//   clk  : clock
//   we   : write strobe, qualified per byte by be
//   be   : byte enables, bit n covers din[8n+7:8n]
//   addr : shared read/write word address
//   din  : write data
//   q    : read data, one cycle after addr is presented
module jtframe_ddr_bram
  import jtframe_ddr_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic           clk,
  input  logic           we,
  input  logic [BEW-1:0] be,
  input  logic [AW-1:0]  addr,
  input  logic [DW-1:0]  din,
  output logic [DW-1:0]  q
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] q_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BEW; i++) begin
      if (we && be[i]) mem[addr][8*i +: 8] <= din[8*i +: 8];
    end
    q_q <= mem[addr];
  end

  assign q = q_q;
endmodule

// File: rtl/jtframe_lfbuf_ddr_resp.sv
// DDRAM burst responder backed by on-chip RAM.
//   rst : synchronous active-high reset
//   clk : single clock, shared with the initiator
//   bus : DDRAM burst port (slave side)
//   err : sticky protocol-error flag
//
//   state      | meaning
//   ST_IDLE    | waiting for a read command or the first beat of a write burst
//   ST_WRBURST | accepting the remaining beats of a write burst
//   ST_RDWAIT  | read latency countdown; last cycle fetches the first word
//   ST_RDBURST | one read beat per cycle on ddram_dout
module jtframe_lfbuf_ddr_resp
  import jtframe_ddr_pkg::*;
#(
  parameter int AW         = 10,
  parameter int LATENCY    = 4,   // must be >= 2
  parameter int BUSY_EVERY = 0
) (
  input  logic                     rst,
  input  logic                     clk,
  jtframe_lfbuf_ddr_resp_if.slave  bus,
  output logic                     err
);
  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [7:0]    rem_q, rem_d;
  logic [7:0]    wait_q, wait_d;
  logic [15:0]   inj_cnt_q, inj_cnt_d;
  logic          err_q, err_d;

  logic          inj, busy, acc_we, acc_rd;
  logic [AW-1:0] s_addr;
  logic [7:0]    cnt_eff;
  logic          cnt_zero;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q;

  wire unused_addr = ^bus.ddram_addr[31:AW+3];

  assign s_addr   = bus.ddram_addr[AW+2:3];
  assign cnt_zero = (bus.ddram_burstcnt == 8'd0);
  assign cnt_eff  = cnt_zero ? 8'd1 : bus.ddram_burstcnt;

  // Free-running stall injector; read beats never look at it.
  always_comb begin
    inj_cnt_d = inj_cnt_q;
    inj       = 1'b0;
    if (BUSY_EVERY != 0) begin
      inj       = (inj_cnt_q == 16'(BUSY_EVERY - 1));
      inj_cnt_d = inj ? 16'd0 : inj_cnt_q + 16'd1;
    end
  end

  assign busy   = inj || (state_q == ST_RDWAIT) || (state_q == ST_RDBURST);
  assign acc_we = bus.ddram_we && !busy;
  assign acc_rd = bus.ddram_rd && !busy;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    wait_d   = wait_q;
    err_d    = err_q;
    ram_we   = 1'b0;
    ram_addr = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_we) begin
          ram_we   = 1'b1;
          ram_addr = s_addr;
          ptr_d    = s_addr + 1'b1;
          rem_d    = cnt_eff - 8'd1;
          if (cnt_eff != 8'd1) state_d = ST_WRBURST;
          if (bus.ddram_rd || cnt_zero) err_d = 1'b1;
        end else if (acc_rd) begin
          ptr_d   = s_addr;
          rem_d   = cnt_eff;
          wait_d  = 8'(LATENCY - 2);
          state_d = ST_RDWAIT;
          if (cnt_zero) err_d = 1'b1;
        end
      end
      ST_WRBURST: begin
        if (acc_rd) err_d = 1'b1;
        if (acc_we) begin
          ram_we = 1'b1;
          ptr_d  = ptr_q + 1'b1;
          rem_d  = rem_q - 8'd1;
          if (rem_q == 8'd1) state_d = ST_IDLE;
        end
      end
      ST_RDWAIT: begin
        // The RAM output is registered, so word 0 is fetched one cycle
        // before the first beat is due.
        if (wait_q == 8'd0) begin
          ptr_d   = ptr_q + 1'b1;
          state_d = ST_RDBURST;
        end else begin
          wait_d = wait_q - 8'd1;
        end
      end
      ST_RDBURST: begin
        // Fetches the word for the following beat; the fetch issued in the
        // final beat cycle is discarded.
        ptr_d = ptr_q + 1'b1;
        rem_d = rem_q - 8'd1;
        if (rem_q == 8'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      rem_q     <= '0;
      wait_q    <= '0;
      inj_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      wait_q    <= wait_d;
      inj_cnt_q <= inj_cnt_d;
      err_q     <= err_d;
    end
  end

  jtframe_ddr_bram #(.AW(AW)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (bus.ddram_be),
    .addr (ram_addr),
    .din  (bus.ddram_din),
    .q    (ram_q)
  );

  assign bus.ddram_busy       = busy;
  assign bus.ddram_dout_ready = (state_q == ST_RDBURST);
  assign bus.ddram_dout       = (state_q == ST_RDBURST) ? ram_q : '0;
  assign err                  = err_q;
endmodule

// File: tb/tb_jtframe_lfbuf_ddr_resp.sv
module tb_jtframe_lfbuf_ddr_resp;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int LAT   = 4;
  localparam int BUSY  = 7;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err;
  int   cyc = 0;
  int   rst_rel = 0;
  int   n_chk = 0;
  int   n_err = 0;

  jtframe_lfbuf_ddr_resp_if bus();

  jtframe_lfbuf_ddr_resp #(.AW(AW), .LATENCY(LAT), .BUSY_EVERY(BUSY)) dut (
    .rst (rst),
    .clk (clk),
    .bus (bus),
    .err (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [63:0] d; int c; } beat_t;
  beat_t       exp_q[$];
  beat_t       mon_e;
  logic [63:0] mem_m [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: every read beat must match the head of the queue,
  // both in data and in the cycle it was predicted for.
  always @(negedge clk) begin
    if (exp_q.size() == 0) begin
      check("no_beat", 64'(bus.ddram_dout_ready), 64'd0);
    end else if (bus.ddram_dout_ready === 1'b1) begin
      mon_e = exp_q.pop_front();
      check("rd_data", bus.ddram_dout, mon_e.d);
      check("rd_cycle", 64'(cyc), 64'(mon_e.c));
    end else if (cyc >= exp_q[0].c) begin
      mon_e = exp_q.pop_front();
      check("beat_missing", 64'(bus.ddram_dout_ready), 64'd1);
    end
  end

  function automatic bit inj_at(input int c);
    return ((c - rst_rel) % BUSY) == BUSY - 1;
  endfunction

  // Cycle in which the last of n beats is accepted when the first beat is
  // presented in cycle c0 and held through every injected stall.
  function automatic int exp_end(input int c0, input int n);
    int c = c0;
    int got = 0;
    while (1) begin
      if (!inj_at(c)) begin
        got++;
        if (got == n) return c;
      end
      c++;
    end
  endfunction

  task automatic model_wr(input int a, input logic [63:0] d, input logic [7:0] be);
    for (int i = 0; i < 8; i++)
      if (be[i]) mem_m[a % DEPTH][8*i +: 8] = d[8*i +: 8];
  endtask

  // Entered and left at posedge+1; t is the accept cycle or -1.
  task automatic wait_accept(output int t);
    bit ok = 1'b0;
    t = -1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (bus.ddram_busy === 1'b0) begin
        ok = 1'b1;
        t  = cyc;
      end
      @(posedge clk); #1;
    end
    check("accept", 64'(ok), 64'd1);
  endtask

  task automatic wr_burst(input int a, input int n, input logic [7:0] be, input bit rnd,
                          output int end_c);
    int beats;
    int t;
    logic [63:0] d;
    beats = (n == 0) ? 1 : n;
    end_c = -1;
    for (int k = 0; k < beats; k++) begin
      d = rnd ? {$urandom, $urandom} : 64'(k);
      bus.ddram_rd       = 1'b0;
      bus.ddram_we       = 1'b1;
      bus.ddram_addr     = 29'(a);
      bus.ddram_burstcnt = 8'(n);
      bus.ddram_din      = d;
      bus.ddram_be       = be;
      wait_accept(t);
      if (t >= 0) begin
        model_wr(a + k, d, be);
        end_c = t;
      end
    end
  endtask

  task automatic rd_burst(input int a, input int n, output int t);
    beat_t b;
    bus.ddram_we       = 1'b0;
    bus.ddram_rd       = 1'b1;
    bus.ddram_addr     = 29'(a);
    bus.ddram_burstcnt = 8'(n);
    wait_accept(t);
    bus.ddram_rd = 1'b0;
    if (t >= 0) begin
      for (int k = 0; k < n; k++) begin
        b.d = mem_m[(a + k) % DEPTH];
        b.c = t + LAT + k;
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    bus.ddram_we = 1'b0;
    bus.ddram_rd = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    bus.ddram_we = 1'b0;
    bus.ddram_rd = 1'b0;
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    rst_rel = cyc;
  endtask

  int t, ec, c0;
  logic [63:0] d;

  initial begin
    bus.ddram_addr     = '0;
    bus.ddram_burstcnt = 8'd1;
    bus.ddram_rd       = 1'b0;
    bus.ddram_we       = 1'b0;
    bus.ddram_din      = '0;
    bus.ddram_be       = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    rst_rel = cyc;
    @(negedge clk);
    check("rst_busy", 64'(bus.ddram_busy), 64'd0);
    check("rst_ready", 64'(bus.ddram_dout_ready), 64'd0);
    check("rst_dout", bus.ddram_dout, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    @(posedge clk); #1;

    // Fill the whole RAM with we held across eight bursts.
    for (int b = 0; b < 8; b++) wr_burst(b * 128, 128, 8'hff, 1'b1, ec);

    // Partial-byte burst under stall injection, read back immediately.
    c0 = cyc;
    wr_burst(256, 128, 8'h03, 1'b0, ec);
    check("wr_duration", 64'(ec), 64'(exp_end(c0, 128)));
    rd_burst(256, 128, t);
    drain();

    // Four contiguous bursts with we held, then four reads.
    for (int b = 0; b < 4; b++) wr_burst(512 + b * 128, 128, 8'hff, 1'b1, ec);
    for (int b = 0; b < 4; b++) begin
      rd_burst(512 + b * 128, 128, t);
      drain();
    end

    // Pointer wrap at the top of the RAM.
    rd_burst(DEPTH - 2, 4, t);
    drain();
    @(negedge clk);
    check("err_clean", 64'(err), 64'd0);
    @(posedge clk); #1;

    // Simultaneous rd and we: the write wins, no read beats.
    d = {$urandom, $urandom};
    bus.ddram_rd       = 1'b1;
    bus.ddram_we       = 1'b1;
    bus.ddram_addr     = 29'(40);
    bus.ddram_burstcnt = 8'd1;
    bus.ddram_din      = d;
    bus.ddram_be       = 8'hff;
    wait_accept(t);
    if (t >= 0) model_wr(40, d, 8'hff);
    bus.ddram_rd = 1'b0;
    bus.ddram_we = 1'b0;
    @(negedge clk);
    check("err_rdwe", 64'(err), 64'd1);
    @(posedge clk); #1;
    idle(8);
    rd_burst(40, 1, t);
    drain();

    do_reset();
    @(negedge clk);
    check("err_after_rst", 64'(err), 64'd0);
    @(posedge clk); #1;

    // burstcnt=0 writes exactly one beat; the next beat opens a new burst.
    wr_burst(60, 0, 8'hff, 1'b1, ec);
    wr_burst(700, 1, 8'hff, 1'b1, ec);
    idle(1);
    @(negedge clk);
    check("err_cnt0", 64'(err), 64'd1);
    @(posedge clk); #1;
    rd_burst(60, 2, t);
    drain();
    rd_burst(700, 1, t);
    drain();

    // Reset during beat 3 of an 8-beat read.
    rd_burst(300, 8, t);
    if (t >= 0) begin
      while (cyc < t + LAT + 3) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      rst_rel = cyc;
      exp_q.delete();
      @(negedge clk);
      check("midrst_busy", 64'(bus.ddram_busy), 64'd0);
      check("midrst_ready", 64'(bus.ddram_dout_ready), 64'd0);
      check("midrst_err", 64'(err), 64'd0);
      @(posedge clk); #1;
    end
    idle(4);
    rd_burst(300, 8, t);
    drain();

    // Random mix of short bursts.
    for (int i = 0; i < 24; i++) begin
      int a, n;
      a = $urandom_range(0, DEPTH - 1);
      n = $urandom_range(1, 16);
      if ($urandom_range(0, 1) == 1) begin
        wr_burst(a, n, 8'($urandom), 1'b1, ec);
      end else begin
        rd_burst(a, n, t);
        drain();
      end
    end
    idle(2);
    @(negedge clk);
    check("err_final", 64'(err), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
